mvb_word_collector: RTL
=======================

// Module: mvb_word_collector
// PURPOSE
//  Serial-to-parallel receive path for the MVB frame datapath; the counterpart of the
//  word serializer on the transmit side. Samples one data/CRC bit per enabled clock,
//  MSB first, and assembles 16-bit words. Writes each word into the receive FIFO through
//  a one-entry holding stage. A frame ending mid-word is flushed as a left-aligned partial word.
// PARAMETERS
//  WORD_W  16  bits per assembled word (MSB received first)
//  CNT_W    5  width of bit counter / valid_bits; must hold WORD_W
// PORTS
//  clk_1d5M    in   1       bit clock; all logic on rising edge
//  reset       in   1       synchronous, active-low reset
//  din         in   1       serial bit, sampled when shift=1
//  shift       in   1       bit-valid enable; high for the whole word/frame body
//  fifo_full   in   1       receive FIFO cannot accept a write this cycle
//  clr_ovf     in   1       clears sticky overflow
//  data_out    out  WORD_W  held word, MSB = first received bit
//  valid_bits  out  CNT_W   number of meaningful bits in data_out (1..WORD_W)
//  last        out  1       held word was flushed by shift falling (frame end, partial word)
//  wr_en       out  1       FIFO write strobe = pending & ~fifo_full (combinational)
//  overflow    out  1       sticky: a word was dropped because the holding stage was occupied
// BEHAVIOUR
//  - Reset (reset=0 at an edge): sreg, cnt, shift_d, pending, data_out, valid_bits, last,
//    overflow all 0; wr_en=0. Reset mid-word discards the partial word without a flush.
//  - States: IDLE (cnt=0, shift_d=0), RX (collecting). IDLE->RX on shift=1; RX->IDLE on shift=0.
//  - shift=1: sreg <= {sreg[WORD_W-2:0], din}; cnt <= cnt+1.
//  - Full word: shift=1 and cnt==WORD_W-1 -> stage event with word {sreg[WORD_W-2:0],din},
//    valid_bits=WORD_W, last=0; cnt wraps to 0; next shift=1 cycle starts the next word
//    with no gap cycles.
//  - Flush: shift=0 and shift_d=1 and cnt!=0 -> stage event with sreg << (WORD_W-cnt)
//    (LSBs zero-padded), valid_bits=cnt, last=1; cnt<=0, sreg<=0.
//    shift falls with cnt==0 -> no event.
//  - shift=0 in IDLE: sreg/cnt stay 0; din is ignored.
//  - Holding stage: a stage event loads data_out/valid_bits/last and sets pending.
//    wr_en=pending&~fifo_full. pending clears at the edge where wr_en=1.
//    data_out stays stable while pending=1.
//  - Latency: the edge that samples the final bit sets pending. wr_en is high in the
//    following cycle if fifo_full=0. fifo_full=1 delays wr_en indefinitely and never drops the word.
//  - Stage event while pending=1 and wr_en=1 in the same cycle: new word loads, pending stays 1,
//    no overflow. Stage event while pending=1 and wr_en=0: new word dropped, held word kept,
//    overflow<=1.
//  - overflow: cleared by clr_ovf=1. A set and a clear in the same cycle: the set wins.
//  - Width rule: cnt counts 0..WORD_W-1 only; valid_bits is never 0 while pending=1.
// STRUCTURE
//  - Package mvb_pkg: MVB_WORD_W=16, MVB_CNT_W=5, rx state enum {RX_IDLE, RX_BUSY},
//    shared with the transmit serializer.
//  - Sub-module mvb_word_stage: one-entry holding register with pending, wr_en and overflow
//    logic. The top level holds the shifter, bit counter, edge detect and FSM.
// TESTING
//  1. shift=1 for 16 cycles, din = 0xA5C3 MSB-first, fifo_full=0 -> a single wr_en pulse one
//     cycle after the 16th sample; data_out=16'hA5C3, valid_bits=16, last=0.
//  2. 5 bits 1,0,1,1,0 then shift=0 -> wr_en once; data_out=16'hB000, valid_bits=5, last=1.
//  3. fifo_full=1 across completion of 0x1234, released 3 cycles later -> wr_en=0 while full;
//     wr_en in the first cycle with full=0, data_out=16'h1234 throughout.
//  4. fifo_full=1 held across words 0x1111 then 0x2222 -> overflow=1, data_out stays 16'h1111;
//     release -> exactly one write; clr_ovf=1 -> overflow=0.
//  5. reset=0 after 8 bits of a word -> no wr_en, all outputs 0; the next 16-bit word 0xFFFF
//     is received correctly with valid_bits=16.
//  6. 32 contiguous bits 0xDEAD,0xBEEF then shift=0 -> two wr_en pulses 16 cycles apart;
//     no flush at shift fall (cnt=0), last=0 on both.

Source files
------------

// File: rtl/mvb_pkg.sv
// Shared MVB datapath constants and receive-FSM state type.
// Used by both the word collector and the transmit serializer.
package mvb_pkg;

    localparam int unsigned MVB_WORD_W = 16;
    localparam int unsigned MVB_CNT_W  = 5;

    typedef enum logic {
        RX_IDLE,
        RX_BUSY
    } rx_state_e;

endpackage

// File: rtl/mvb_word_collector_if.sv
// Serial receive bus between the bit source / receive FIFO and the word collector.
interface mvb_word_collector_if;
    import mvb_pkg::*;

    logic                  din;
    logic                  shift;
    logic                  fifo_full;
    logic                  clr_ovf;
    logic [MVB_WORD_W-1:0] data_out;
    logic [MVB_CNT_W-1:0]  valid_bits;
    logic                  last;
    logic                  wr_en;
    logic                  overflow;

    modport master (
        output din, shift, fifo_full, clr_ovf,
        input  data_out, valid_bits, last, wr_en, overflow
    );

    modport slave (
        input  din, shift, fifo_full, clr_ovf,
        output data_out, valid_bits, last, wr_en, overflow
    );

endinterface

// File: rtl/mvb_word_stage.sv
// One-entry holding register in front of the receive FIFO, with write strobe
// and sticky overflow for words that arrive while the entry is still occupied.
module mvb_word_stage
    import mvb_pkg::*;
#(
    parameter int unsigned WORD_W = MVB_WORD_W,
    parameter int unsigned CNT_W  = MVB_CNT_W
) (
    input  logic              clk_1d5M,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_bits,
    input  logic              load_last,
    input  logic              fifo_full,
    input  logic              clr_ovf,
    output logic [WORD_W-1:0] data_out,
    output logic [CNT_W-1:0]  valid_bits,
    output logic              last,
    output logic              wr_en,
    output logic              overflow
);

    logic pending;
    logic drop;

    assign wr_en = pending & ~fifo_full;
    // The entry is free if empty or if it is being written out this very cycle.
    assign drop  = load & pending & ~wr_en;

    always_ff @(posedge clk_1d5M) begin
        if (!reset) begin
            pending    <= 1'b0;
            data_out   <= '0;
            valid_bits <= '0;
            last       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (load && !drop) begin
                pending    <= 1'b1;
                data_out   <= load_data;
                valid_bits <= load_bits;
                last       <= load_last;
            end else if (wr_en) begin
                pending <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mvb_word_collector.sv
// MVB serial-to-parallel receive path: MSB-first shifter, bit counter and frame-end
// detect feeding a one-entry holding stage towards the receive FIFO.
module mvb_word_collector
    import mvb_pkg::*;
#(
    parameter int unsigned WORD_W = MVB_WORD_W,
    parameter int unsigned CNT_W  = MVB_CNT_W
) (
    input  logic                 clk_1d5M,
    input  logic                 reset,
    mvb_word_collector_if.slave  bus
);

    rx_state_e         state;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt;
    logic              full_word;
    logic              flush;
    logic              stage_ev;
    logic [WORD_W-1:0] ev_data;
    logic [CNT_W-1:0]  ev_bits;

    logic [WORD_W-1:0] st_data;
    logic [CNT_W-1:0]  st_bits;
    logic              st_last;
    logic              st_wr_en;
    logic              st_overflow;

    assign shifted = {sreg[WORD_W-2:0], bus.din};

    // RX_BUSY doubles as the registered copy of shift used for falling-edge detect.
    always_comb begin
        full_word = bus.shift && (cnt == CNT_W'(WORD_W - 1));
        flush     = !bus.shift && (state == RX_BUSY) && (cnt != '0);
        stage_ev  = full_word || flush;
        ev_data   = full_word ? shifted : (sreg << (CNT_W'(WORD_W) - cnt));
        ev_bits   = full_word ? CNT_W'(WORD_W) : cnt;
    end

    always_ff @(posedge clk_1d5M) begin
        if (!reset) begin
            state <= RX_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                RX_IDLE: if (bus.shift) state <= RX_BUSY;
                RX_BUSY: if (!bus.shift) state <= RX_IDLE;
                default: state <= RX_IDLE;
            endcase

            if (bus.shift) begin
                sreg <= shifted;
                cnt  <= full_word ? '0 : cnt + 1'b1;
            end else begin
                sreg <= '0;
                cnt  <= '0;
            end
        end
    end

    mvb_word_stage #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_stage (
        .clk_1d5M   (clk_1d5M),
        .reset      (reset),
        .load       (stage_ev),
        .load_data  (ev_data),
        .load_bits  (ev_bits),
        .load_last  (flush),
        .fifo_full  (bus.fifo_full),
        .clr_ovf    (bus.clr_ovf),
        .data_out   (st_data),
        .valid_bits (st_bits),
        .last       (st_last),
        .wr_en      (st_wr_en),
        .overflow   (st_overflow)
    );

    assign bus.data_out   = st_data;
    assign bus.valid_bits = st_bits;
    assign bus.last       = st_last;
    assign bus.wr_en      = st_wr_en;
    assign bus.overflow   = st_overflow;

endmodule
